// File: rtl/activation_unit.sv
// Multi-lane activation (pass/ReLU/leaky/clamp) on signed Q(WIDTH-FRAC).FRAC data, 2-stage valid/ready pipeline.
// Beat accepted at edge N is on out_valid after edge N+1; in_ready drops only when both stages are full and out_ready is low.
module activation_unit #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8,
    parameter int LANES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_we,
    input  logic [1:0]             cfg_mode,
    input  logic [WIDTH-1:0]       cfg_alpha,
    input  logic [WIDTH-1:0]       cfg_clamp_hi,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_data,
    output logic [LANES-1:0]       out_sat,
    output logic                   sat_sticky
);
    localparam logic signed [WIDTH-1:0]   L_MAX  = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0]   L_MIN  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [WIDTH-1:0]   L_ZERO = '0;
    localparam logic signed [2*WIDTH-1:0] L_PMAX = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [2*WIDTH-1:0] L_PMIN = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    logic [1:0]                r_mode;
    logic signed [WIDTH-1:0]   r_alpha;
    logic signed [WIDTH-1:0]   r_clamp_hi;

    logic                      r_s1_vld;
    logic [1:0]                r_s1_mode;
    logic signed [WIDTH-1:0]   r_s1_chi;
    logic signed [WIDTH-1:0]   r_s1_x [LANES];
    logic signed [WIDTH-1:0]   r_s1_p [LANES];
    logic [LANES-1:0]          r_s1_psat;

    logic                      r_out_vld;
    logic [LANES*WIDTH-1:0]    r_out_dat;
    logic [LANES-1:0]          r_out_sat;
    logic                      r_sticky;

    logic                      w_s2_en;
    logic                      w_s1_en;
    logic signed [WIDTH-1:0]   w_x    [LANES];
    logic signed [2*WIDTH-1:0] w_prod [LANES];
    logic signed [2*WIDTH-1:0] w_shf  [LANES];
    logic signed [WIDTH-1:0]   w_p    [LANES];
    logic [LANES-1:0]          w_psat;
    logic [LANES*WIDTH-1:0]    w_y;
    logic [LANES-1:0]          w_ysat;

    assign w_s2_en  = !r_out_vld || out_ready;
    assign w_s1_en  = !r_s1_vld || w_s2_en;
    assign in_ready = w_s1_en;

    // Leaky product is saturated here so stage 2 only has to select.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            w_x[i]    = in_data[i*WIDTH +: WIDTH];
            w_prod[i] = (2*WIDTH)'(w_x[i]) * (2*WIDTH)'(r_alpha);
            w_shf[i]  = w_prod[i] >>> FRAC;
            w_psat[i] = (w_shf[i] > L_PMAX) || (w_shf[i] < L_PMIN);
            if (w_shf[i] > L_PMAX)
                w_p[i] = L_MAX;
            else if (w_shf[i] < L_PMIN)
                w_p[i] = L_MIN;
            else
                w_p[i] = w_shf[i][WIDTH-1:0];
        end
    end

    always_comb begin
        w_y    = '0;
        w_ysat = '0;
        for (int i = 0; i < LANES; i++) begin
            case (r_s1_mode)
                2'd1: w_y[i*WIDTH +: WIDTH] = (r_s1_x[i] > L_ZERO) ? r_s1_x[i] : L_ZERO;
                2'd2: begin
                    w_y[i*WIDTH +: WIDTH] = (r_s1_x[i] > L_ZERO) ? r_s1_x[i] : r_s1_p[i];
                    w_ysat[i]             = (r_s1_x[i] <= L_ZERO) && r_s1_psat[i];
                end
                2'd3: begin
                    if (r_s1_x[i] > L_ZERO)
                        w_y[i*WIDTH +: WIDTH] = (r_s1_x[i] > r_s1_chi) ? r_s1_chi : r_s1_x[i];
                    else
                        w_y[i*WIDTH +: WIDTH] = (r_s1_chi < L_ZERO) ? r_s1_chi : L_ZERO;
                    w_ysat[i] = r_s1_x[i] > r_s1_chi;
                end
                default: w_y[i*WIDTH +: WIDTH] = r_s1_x[i];
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode     <= 2'd0;
            r_alpha    <= L_ZERO;
            r_clamp_hi <= L_MAX;
        end else if (cfg_we) begin
            r_mode     <= cfg_mode;
            r_alpha    <= cfg_alpha;
            r_clamp_hi <= cfg_clamp_hi;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld  <= 1'b0;
            r_s1_mode <= 2'd0;
            r_s1_chi  <= L_MAX;
            r_s1_psat <= '0;
            for (int i = 0; i < LANES; i++) begin
                r_s1_x[i] <= L_ZERO;
                r_s1_p[i] <= L_ZERO;
            end
        end else if (w_s1_en) begin
            r_s1_vld <= in_valid;
            if (in_valid) begin
                r_s1_mode <= r_mode;
                r_s1_chi  <= r_clamp_hi;
                r_s1_psat <= w_psat;
                for (int i = 0; i < LANES; i++) begin
                    r_s1_x[i] <= w_x[i];
                    r_s1_p[i] <= w_p[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_vld <= 1'b0;
            r_out_dat <= '0;
            r_out_sat <= '0;
        end else if (w_s2_en) begin
            r_out_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_out_dat <= w_y;
                r_out_sat <= w_ysat;
            end
        end
    end

    // Setting takes priority over a config-write clear in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_sticky <= 1'b0;
        else if (w_s2_en && r_s1_vld && (|w_ysat))
            r_sticky <= 1'b1;
        else if (cfg_we)
            r_sticky <= 1'b0;
    end

    assign out_valid  = r_out_vld;
    assign out_data   = r_out_dat;
    assign out_sat    = r_out_sat;
    assign sat_sticky = r_sticky;
endmodule

// File: tb/tb_activation_unit.sv
// Directed bench for activation_unit: reference model fed from observed handshakes, scoreboard checked every cycle,
// plus literal expectations for the hand-computed vectors.
`timescale 1ns/1ps
module tb_activation_unit;
    localparam int W    = 16;
    localparam int F    = 8;
    localparam int L    = 4;
    localparam int LW   = W * L;
    localparam int MAXV = (1 << (W-1)) - 1;
    localparam int MINV = -(1 << (W-1));

    typedef struct {
        logic [LW-1:0] d;
        logic [L-1:0]  s;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_we = 1'b0;
    logic [1:0]    cfg_mode = 2'd0;
    logic [W-1:0]  cfg_alpha = '0;
    logic [W-1:0]  cfg_clamp_hi = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [LW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [LW-1:0] out_data;
    logic [L-1:0]  out_sat;
    logic          sat_sticky;

    int n_vec = 0;
    int n_err = 0;

    activation_unit #(.WIDTH(W), .FRAC(F), .LANES(L)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_mode(cfg_mode),
        .cfg_alpha(cfg_alpha), .cfg_clamp_hi(cfg_clamp_hi),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sat(out_sat), .sat_sticky(sat_sticky)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic int sx(input logic [W-1:0] v);
        logic signed [W-1:0] t;
        t = v;
        return int'(t);
    endfunction

    // Reference: plain integer arithmetic on each lane.
    function automatic beat_t model(input int mode, input int alpha, input int chi, input logic [LW-1:0] din);
        beat_t r;
        int x, y;
        longint p;
        logic [W-1:0] yv;
        r.d = '0;
        r.s = '0;
        for (int i = 0; i < L; i++) begin
            x = sx(din[i*W +: W]);
            p = (longint'(x) * longint'(alpha)) >>> F;
            y = x;
            case (mode)
                1: y = (x > 0) ? x : 0;
                2: begin
                    if (x > 0) y = x;
                    else if (p > MAXV) y = MAXV;
                    else if (p < MINV) y = MINV;
                    else y = int'(p);
                    r.s[i] = (x <= 0) && (p > MAXV || p < MINV);
                end
                3: begin
                    y = (x > 0) ? x : 0;
                    if (y > chi) y = chi;
                    r.s[i] = x > chi;
                end
                default: y = x;
            endcase
            yv = y[W-1:0];
            r.d[i*W +: W] = yv;
        end
        return r;
    endfunction

    beat_t         q[$];
    int            m_mode = 0, m_alpha = 0, m_chi = MAXV;
    logic          exp_sticky = 1'b0;
    logic          prev_stall = 1'b0, prev_xfer = 1'b0, prev_vld = 1'b0, prev_cfg = 1'b0;
    logic [LW-1:0] prev_dat = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            m_mode = 0; m_alpha = 0; m_chi = MAXV;
            exp_sticky = 1'b0;
            prev_stall = 1'b0; prev_xfer = 1'b0; prev_vld = 1'b0; prev_cfg = 1'b0;
        end else begin
            if (out_valid && (!prev_vld || prev_xfer) && q.size() > 0 && q[0].s != '0)
                exp_sticky = 1'b1;
            else if (prev_cfg)
                exp_sticky = 1'b0;
            chk("sticky", LW'(sat_sticky), LW'(exp_sticky));
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_beat", LW'(out_valid), '0);
                end else begin
                    chk("sb_data", out_data, q[0].d);
                    chk("sb_sat", LW'(out_sat), LW'(q[0].s));
                end
                if (prev_stall) chk("stall_hold", out_data, prev_dat);
            end else if (prev_stall) begin
                chk("stall_vld", LW'(out_valid), LW'(1));
            end
            if (in_valid && in_ready)
                q.push_back(model(m_mode, m_alpha, m_chi, in_data));
            if (cfg_we) begin
                m_mode = int'(cfg_mode); m_alpha = sx(cfg_alpha); m_chi = sx(cfg_clamp_hi);
            end
            prev_xfer  = out_valid && out_ready;
            if (prev_xfer && q.size() > 0) void'(q.pop_front());
            prev_stall = out_valid && !out_ready;
            prev_dat   = out_data;
            prev_vld   = out_valid;
            prev_cfg   = cfg_we;
        end
    end

    // All stimulus tasks start and end at posedge+1.
    task automatic set_cfg(input logic [1:0] md, input logic [W-1:0] al, input logic [W-1:0] hi);
        cfg_we = 1'b1; cfg_mode = md; cfg_alpha = al; cfg_clamp_hi = hi;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic send(input logic [LW-1:0] d);
        int t = 0;
        in_valid = 1'b1; in_data = d;
        @(negedge clk);
        while (!in_ready && t < 200) begin @(negedge clk); t++; end
        if (!in_ready) chk("send_timeout", LW'(in_ready), LW'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic expect_out(input string nm, input logic [LW-1:0] d, input logic [L-1:0] s);
        int t = 0;
        @(negedge clk);
        while (!(out_valid && out_ready) && t < 200) begin @(negedge clk); t++; end
        chk({nm, "_vld"}, LW'(out_valid), LW'(1));
        chk({nm, "_dat"}, out_data, d);
        chk({nm, "_sat"}, LW'(out_sat), LW'(s));
        @(posedge clk); #1;
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((q.size() != 0 || out_valid) && t < 200) begin @(negedge clk); t++; end
        chk("drain", LW'(q.size()), '0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [LW-1:0] v;
        int vi;
        #12;
        chk("rst_out_vld", LW'(out_valid), '0);
        chk("rst_out_dat", out_data, '0);
        chk("rst_out_sat", LW'(out_sat), '0);
        chk("rst_sticky", LW'(sat_sticky), '0);
        chk("rst_in_rdy", LW'(in_ready), LW'(1));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset config is pass-through; also pins the two-stage latency.
        in_valid = 1'b1; in_data = 64'h8000_FF00_0001_0000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("lat_n1_vld", LW'(out_valid), '0);
        @(posedge clk); #1;
        chk("lat_n2_vld", LW'(out_valid), LW'(1));
        chk("lat_n2_dat", out_data, 64'h8000_FF00_0001_0000);
        @(posedge clk); #1;

        set_cfg(2'd2, 16'h001A, 16'h7FFF);
        fork
            send(64'h7FFF_0000_FD00_0300);
            expect_out("leaky", 64'h7FFF_0000_FFB2_0300, 4'b0000);
        join

        set_cfg(2'd2, 16'hFF00, 16'h7FFF);
        fork
            send(64'h0000_0000_0000_8000);
            expect_out("leaky_sat", 64'h0000_0000_0000_7FFF, 4'b0001);
        join
        chk("sticky_set", LW'(sat_sticky), LW'(1));
        set_cfg(2'd2, 16'hFF00, 16'h7FFF);
        chk("sticky_clr", LW'(sat_sticky), '0);

        set_cfg(2'd3, 16'h0000, 16'h0600);
        fork
            send(64'h0600_0280_FF00_0A00);
            expect_out("clamp", 64'h0600_0280_0000_0600, 4'b0001);
        join

        fork
            begin
                for (int b = 0; b < 6; b++) begin
                    for (int i = 0; i < L; i++) begin
                        vi = b * 768 - 2048 + i * 336;
                        v[i*W +: W] = vi[W-1:0];
                    end
                    send(v);
                end
            end
            begin
                @(posedge clk); #1;
                out_ready = 1'b0;
                repeat (4) @(posedge clk);
                @(negedge clk);
                chk("stall_in_rdy", LW'(in_ready), '0);
                chk("stall_out_vld", LW'(out_valid), LW'(1));
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        wait_drain();

        set_cfg(2'd1, 16'h0000, 16'h7FFF);
        fork
            begin
                in_valid = 1'b1; in_data = 64'h0200_FF00_0200_FF00;
                @(posedge clk); #1;
                in_data = 64'h8000_0001_FE00_0000;
                cfg_we = 1'b1; cfg_mode = 2'd0;
                @(posedge clk); #1;
                cfg_we = 1'b0;
                in_data = 64'hFD00_FD00_FD00_FD00;
                @(posedge clk); #1;
                in_valid = 1'b0;
            end
            begin
                expect_out("swA", 64'h0200_0000_0200_0000, 4'b0000);
                expect_out("swB", 64'h0000_0001_0000_0000, 4'b0000);
                expect_out("swC", 64'hFD00_FD00_FD00_FD00, 4'b0000);
            end
        join
        wait_drain();

        out_ready = 1'b0;
        send(64'h0100_0100_0100_0100);
        send(64'h0200_0200_0200_0200);
        chk("pre_rst_vld", LW'(out_valid), LW'(1));
        #1 rst_n = 1'b0;
        #1;
        chk("arst_out_vld", LW'(out_valid), '0);
        chk("arst_out_dat", out_data, '0);
        chk("arst_out_sat", LW'(out_sat), '0);
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("post_rst_no_stale", LW'(out_valid), '0);

        fork
            send(64'hC000_0000_7FFF_8001);
            expect_out("post_rst_pass", 64'hC000_0000_7FFF_8001, 4'b0000);
        join

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
